sdram_fifo_ctrl: RTL and testbench
==================================

SDRAM_FIFO_CTRL -- requirements
Module: sdram_fifo_ctrl

Interface
REQ-001 The interface SHALL have one clock and a synchronous, active-high reset: clk is the single clock and rst is synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 16, data word width.
- ADDR_W, 23, SDRAM linear address {bank[1:0], row[11:0], col[8:0]}.
- BURST_LEN, 8, words per SDRAM burst.
- FIFO_DEPTH, 32, depth of each internal FIFO; power of two and at least 2*BURST_LEN.
- BASE_ADDR, 0, first address of the ring region.
- END_ADDR, 2**23-1, last address of the ring region.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- usr_wr_en, in, 1, push usr_wr_data into the write FIFO.
- usr_wr_data, in, DATA_W, user write word.
- usr_wr_full, out, 1, write FIFO full.
- usr_ovf, out, 1, sticky; set when a push is dropped.
- usr_rd_en, in, 1, pop the read FIFO.
- usr_rd_data, out, DATA_W, read FIFO head word.
- usr_rd_empty, out, 1, read FIFO empty.
- rd_run, in, 1, enables read bursts.
- sd_wr_req, out, 1, write burst request, held high until the burst completes.
- sd_wr_addr, out, ADDR_W, burst start address.
- sd_wr_ack, in, 1, one pulse per word accepted by the controller.
- sd_wr_data, out, DATA_W, write FIFO head word.
- sd_rd_req, out, 1, read burst request, held high until the burst completes.
- sd_rd_addr, out, ADDR_W, burst start address.
- sd_rd_valid, in, 1, one pulse per returned word.
- sd_rd_data, in, DATA_W, returned word.

Function
REQ-004 The FSM SHALL have three states: IDLE, WR_BURST and RD_BURST.
REQ-005 In IDLE, when the write FIFO level is at least BURST_LEN, the FSM SHALL go to WR_BURST and assert sd_wr_req on the next cycle.
REQ-006 Otherwise in IDLE, the FSM SHALL go to RD_BURST when all of the following hold: rd_run=1, read FIFO free space is at least BURST_LEN, and burst_cnt_avail>0.
REQ-007 When both write and read conditions hold in the same cycle, the write SHALL win.
REQ-008 A burst SHALL never be preempted.
REQ-009 In WR_BURST, each sd_wr_ack SHALL pop one word, so that sd_wr_data always shows the FIFO head with zero added latency.
REQ-010 After the BURST_LEN-th ack, sd_wr_req SHALL deassert in the same cycle the FSM returns to IDLE, and sd_wr_addr SHALL advance by BURST_LEN.
REQ-011 In RD_BURST, each sd_rd_valid SHALL push sd_rd_data into the read FIFO.
REQ-012 After the BURST_LEN-th valid, sd_rd_req SHALL drop, the FSM SHALL return to IDLE, and sd_rd_addr SHALL advance by BURST_LEN.
REQ-013 Address wrap: if addr+BURST_LEN > END_ADDR, the next address SHALL be BASE_ADDR.
REQ-014 burst_cnt_avail SHALL be an internal counter of written-but-unread bursts: +1 per completed write burst, -1 per completed read burst, and a simultaneous +1/-1 SHALL net to zero.
REQ-015 When burst_cnt_avail reaches the ring capacity, write bursts SHALL stall until a read burst completes.
REQ-016 A push while the write FIFO is full SHALL be dropped and SHALL set usr_ovf, which stays set until reset.
REQ-017 A pop while the read FIFO is empty SHALL be ignored, and usr_rd_data SHALL hold its value.
REQ-018 A simultaneous push and pop on the same FIFO SHALL leave its level unchanged.
REQ-019 An sd_wr_ack or sd_rd_valid arriving outside the matching burst state SHALL be ignored.
REQ-020 usr_rd_data SHALL be first-word-fall-through.

Reset
REQ-021 While rst=1, the block SHALL hold the following state:
- FSM in IDLE.
- sd_wr_req=0 and sd_rd_req=0.
- sd_wr_addr=BASE_ADDR and sd_rd_addr=BASE_ADDR.
- Both FIFOs empty: usr_wr_full=0 and usr_rd_empty=1.
- usr_ovf=0.
- burst_cnt_avail=0.
- sd_wr_data and usr_rd_data at 0.
REQ-022 Reset asserted mid-burst SHALL drop the request on the next clock edge and discard the partial burst.

Configuration
REQ-023 With SDRAM_FIFO_RD_PATH_EN defined, the read FIFO, the RD_BURST state and all read ports SHALL be functional.
REQ-024 Without SDRAM_FIFO_RD_PATH_EN, the block SHALL behave as follows:
- The read logic is not built.
- sd_rd_req is tied to 0, usr_rd_empty to 1, and usr_rd_data to 0.
- Read-side inputs are ignored.
- burst_cnt_avail only increments and saturates, and write bursts stall at ring capacity.

Structure
REQ-025 The shared package sdram_fifo_pkg SHALL contain the FSM state enum and the default values of DATA_W, ADDR_W and BURST_LEN.
REQ-026 Both FIFOs SHALL be instances of one sub-module, sync_fifo_fwft, parameterised by width and depth, with level, full and empty outputs.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Push 8 words 0x0001..0x0008 -> sd_wr_req rises with sd_wr_addr=0; 8 acks return 0x0001..0x0008 in order; req drops; next sd_wr_addr=8.
- With rd_run=1 after the first write burst -> sd_rd_req with sd_rd_addr=0; 8 valids carrying 0xA0..0xA7 -> usr_rd_data pops 0xA0..0xA7; usr_rd_empty=1 afterwards.
- Write and read conditions true in the same cycle -> WR_BURST is taken first, and RD_BURST follows immediately after.
- END_ADDR=23, four write bursts -> addresses 0, 8, 16, 0.
- 33 pushes with no acks -> usr_wr_full after 32 pushes, the 33rd is dropped, and usr_ovf=1.
- rst asserted after the 3rd ack -> sd_wr_req=0 next cycle, FIFO empty, and the next burst starts at BASE_ADDR.

Source files
------------

// File: rtl/sdram_fifo_pkg.sv
// Shared types and default widths for the SDRAM ring-buffer FIFO controller.
package sdram_fifo_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 23;
    localparam int BURST_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: head_o always shows the oldest
// stored word. Pushes while full and pops while empty are ignored.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // level follows accepted pushes minus accepted pops
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    // storage and pointers; storage cleared so the head reads 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// SDRAM-backed ring FIFO controller. User words are staged in a write FIFO
// and flushed to SDRAM in bursts; bursts are read back into a read FIFO.
// Macro SDRAM_FIFO_RD_PATH_EN builds the read path; without it only write
// bursts run and the ring stalls once full.
//
// state    | meaning
// IDLE     | choose next burst, write has priority
// WR_BURST | sd_wr_req high, one write-FIFO pop per sd_wr_ack
// RD_BURST | sd_rd_req high, one read-FIFO push per sd_rd_valid
module sdram_fifo_ctrl
    import sdram_fifo_pkg::*;
#(
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          BURST_LEN  = BURST_LEN_DEF,
    parameter int          FIFO_DEPTH = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned END_ADDR   = 2**23-1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usr_wr_en,
    input  logic [DATA_W-1:0] usr_wr_data,
    output logic              usr_wr_full,
    output logic              usr_ovf,
    input  logic              usr_rd_en,
    output logic [DATA_W-1:0] usr_rd_data,
    output logic              usr_rd_empty,
    input  logic              rd_run,
    output logic              sd_wr_req,
    output logic [ADDR_W-1:0] sd_wr_addr,
    input  logic              sd_wr_ack,
    output logic [DATA_W-1:0] sd_wr_data,
    output logic              sd_rd_req,
    output logic [ADDR_W-1:0] sd_rd_addr,
    input  logic              sd_rd_valid,
    input  logic [DATA_W-1:0] sd_rd_data
);

    localparam int          LW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          BW          = $clog2(BURST_LEN);
    // number of distinct burst start addresses in the ring
    localparam int unsigned RING_BURSTS = (END_ADDR - BASE_ADDR) / BURST_LEN + 1;
    localparam int          CNT_W       = $clog2(RING_BURSTS + 1);

    ctrl_state_e       state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  avail_q, avail_d;
    logic              ovf_q;
    logic              wr_done, rd_done;
    logic              wr_go, rd_go;
    logic              wr_beat, rd_beat;
    logic              last_beat;
    logic [LW-1:0]     wr_level;
    logic              wr_empty_unused;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + (ADDR_W+1)'(BURST_LEN);
        if (sum > (ADDR_W+1)'(END_ADDR)) begin
            return ADDR_W'(BASE_ADDR);
        end
        return sum[ADDR_W-1:0];
    endfunction

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (usr_wr_en),
        .push_data_i (usr_wr_data),
        .pop_i       (wr_beat),
        .head_o      (sd_wr_data),
        .level_o     (wr_level),
        .full_o      (usr_wr_full),
        .empty_o     (wr_empty_unused)
    );

    assign wr_beat   = (state_q == WR_BURST) && sd_wr_ack;
    assign wr_go     = (wr_level >= LW'(BURST_LEN)) && (avail_q < CNT_W'(RING_BURSTS));
    assign last_beat = (beat_q == BW'(BURST_LEN - 1));
    assign sd_wr_req = (state_q == WR_BURST);
    assign sd_wr_addr = wr_addr_q;
    assign usr_ovf   = ovf_q;

`ifdef SDRAM_FIFO_RD_PATH_EN
    logic [LW-1:0] rd_level;
    logic          rd_full_unused;

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rd_beat),
        .push_data_i (sd_rd_data),
        .pop_i       (usr_rd_en),
        .head_o      (usr_rd_data),
        .level_o     (rd_level),
        .full_o      (rd_full_unused),
        .empty_o     (usr_rd_empty)
    );

    assign rd_beat   = (state_q == RD_BURST) && sd_rd_valid;
    assign rd_go     = rd_run && (rd_level <= LW'(FIFO_DEPTH - BURST_LEN)) && (avail_q != '0);
    assign sd_rd_req = (state_q == RD_BURST);
`else
    logic unused_rd_inputs;

    assign unused_rd_inputs = ^{rd_run, usr_rd_en, sd_rd_valid, sd_rd_data};
    assign rd_beat      = 1'b0;
    assign rd_go        = 1'b0;
    assign sd_rd_req    = 1'b0;
    assign usr_rd_empty = 1'b1;
    assign usr_rd_data  = '0;
`endif
    assign sd_rd_addr = rd_addr_q;

    // burst sequencing: pick a burst in IDLE, count beats, advance address on the last one
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_done   = 1'b0;
        rd_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (wr_go) begin
                    state_d = WR_BURST;
                end else if (rd_go) begin
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                if (wr_beat) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        beat_d    = '0;
                        wr_addr_d = next_addr(wr_addr_q);
                        wr_done   = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RD_BURST: begin
                if (rd_beat) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        beat_d    = '0;
                        rd_addr_d = next_addr(rd_addr_q);
                        rd_done   = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // bursts held in SDRAM: up on write completion, down on read completion, clamped to the ring
    always_comb begin
        avail_d = avail_q;
        if (wr_done && !rd_done && (avail_q != CNT_W'(RING_BURSTS))) begin
            avail_d = avail_q + 1'b1;
        end else if (rd_done && !wr_done && (avail_q != '0)) begin
            avail_d = avail_q - 1'b1;
        end
    end

    // controller registers; the overflow flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wr_addr_q <= ADDR_W'(BASE_ADDR);
            rd_addr_q <= ADDR_W'(BASE_ADDR);
            avail_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            avail_q   <= avail_d;
            ovf_q     <= ovf_q | (usr_wr_en & usr_wr_full);
        end
    end

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Bench for sdram_fifo_ctrl with a 24-word ring (END_ADDR=23). Builds with
// or without SDRAM_FIFO_RD_PATH_EN; a queue-based model tracks every output.
module tb_sdram_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 23;
    localparam int BL    = 8;
    localparam int DEPTH = 32;
    localparam int BASE  = 0;
    localparam int ENDA  = 23;
    localparam int RING  = 3;   // start addresses 0, 8, 16
`ifdef SDRAM_FIFO_RD_PATH_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          usr_wr_en;
    logic [DW-1:0] usr_wr_data;
    logic          usr_wr_full;
    logic          usr_ovf;
    logic          usr_rd_en;
    logic [DW-1:0] usr_rd_data;
    logic          usr_rd_empty;
    logic          rd_run;
    logic          sd_wr_req;
    logic [AW-1:0] sd_wr_addr;
    logic          sd_wr_ack;
    logic [DW-1:0] sd_wr_data;
    logic          sd_rd_req;
    logic [AW-1:0] sd_rd_addr;
    logic          sd_rd_valid;
    logic [DW-1:0] sd_rd_data;

    sdram_fifo_ctrl #(.END_ADDR(ENDA)) dut (
        .clk(clk), .rst(rst),
        .usr_wr_en(usr_wr_en), .usr_wr_data(usr_wr_data), .usr_wr_full(usr_wr_full),
        .usr_ovf(usr_ovf), .usr_rd_en(usr_rd_en), .usr_rd_data(usr_rd_data),
        .usr_rd_empty(usr_rd_empty), .rd_run(rd_run),
        .sd_wr_req(sd_wr_req), .sd_wr_addr(sd_wr_addr), .sd_wr_ack(sd_wr_ack),
        .sd_wr_data(sd_wr_data), .sd_rd_req(sd_rd_req), .sd_rd_addr(sd_rd_addr),
        .sd_rd_valid(sd_rd_valid), .sd_rd_data(sd_rd_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // reference model: FIFO contents as queues, burst activity as a mode number
    logic [DW-1:0] m_wq[$];
    logic [DW-1:0] m_rq[$];
    int m_mode;    // 0 none, 1 write burst, 2 read burst
    int m_beats;
    int m_waddr;
    int m_raddr;
    int m_avail;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nxt(input int a);
        return (a + BL > ENDA) ? BASE : a + BL;
    endfunction

    task automatic model_update();
        int  wsz;
        int  rsz;
        bit  ack;
        bit  vld;
        if (rst) begin
            m_wq.delete();
            m_rq.delete();
            m_mode = 0; m_beats = 0; m_waddr = BASE; m_raddr = BASE; m_avail = 0; m_ovf = 0;
            return;
        end
        wsz = m_wq.size();
        rsz = m_rq.size();
        ack = sd_wr_ack && (m_mode == 1);
        vld = RD_EN && sd_rd_valid && (m_mode == 2);
        if (usr_wr_en) begin
            if (wsz == DEPTH) m_ovf = 1'b1;
            else m_wq.push_back(usr_wr_data);
        end
        if (ack && wsz > 0) void'(m_wq.pop_front());
        if (RD_EN && usr_rd_en && rsz > 0) void'(m_rq.pop_front());
        if (vld && rsz < DEPTH) m_rq.push_back(sd_rd_data);
        case (m_mode)
            0: begin
                m_beats = 0;
                if (wsz >= BL && m_avail < RING) m_mode = 1;
                else if (RD_EN && rd_run && (DEPTH - rsz) >= BL && m_avail > 0) m_mode = 2;
            end
            1: if (ack) begin
                m_beats++;
                if (m_beats == BL) begin m_mode = 0; m_waddr = nxt(m_waddr); m_avail++; end
            end
            2: if (vld) begin
                m_beats++;
                if (m_beats == BL) begin m_mode = 0; m_raddr = nxt(m_raddr); m_avail--; end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic model_check();
        chk("wr_req",   sd_wr_req,    m_mode == 1);
        chk("rd_req",   sd_rd_req,    m_mode == 2);
        chk("wr_addr",  sd_wr_addr,   m_waddr);
        chk("rd_addr",  sd_rd_addr,   m_raddr);
        chk("wr_full",  usr_wr_full,  m_wq.size() == DEPTH);
        chk("ovf",      usr_ovf,      m_ovf);
        chk("rd_empty", usr_rd_empty, m_rq.size() == 0);
        if (m_wq.size() > 0) chk("wr_data", sd_wr_data, m_wq[0]);
`ifdef SDRAM_FIFO_RD_PATH_EN
        if (m_rq.size() > 0) chk("rd_data", usr_rd_data, m_rq[0]);
`else
        chk("rd_data_tied", usr_rd_data, 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic clr_in();
        rst = 0; usr_wr_en = 0; usr_wr_data = '0; usr_rd_en = 0; rd_run = 0;
        sd_wr_ack = 0; sd_rd_valid = 0; sd_rd_data = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            usr_wr_en = 1; usr_wr_data = DW'(base + i);
            step();
        end
        usr_wr_en = 0;
    endtask

    task automatic acks(input int n);
        sd_wr_ack = 1;
        repeat (n) step();
        sd_wr_ack = 0;
    endtask

    task automatic valids(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            sd_rd_valid = 1; sd_rd_data = DW'(base + i);
            step();
        end
        sd_rd_valid = 0;
    endtask

    task automatic wait_req(input bit rd, input int budget);
        int n = 0;
        while (((rd ? sd_rd_req : sd_wr_req) !== 1'b1) && n < budget) begin
            step();
            n++;
        end
        if (rd) chk("wait_rd_req", sd_rd_req, 1);
        else    chk("wait_wr_req", sd_wr_req, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_exp [4];
        wrap_exp[0] = 0; wrap_exp[1] = 8; wrap_exp[2] = 16; wrap_exp[3] = 0;

        // reset state
        do_reset();
        chk("rst_wr_req",  sd_wr_req, 0);
        chk("rst_rd_req",  sd_rd_req, 0);
        chk("rst_wr_addr", sd_wr_addr, BASE);
        chk("rst_rd_addr", sd_rd_addr, BASE);
        chk("rst_full",    usr_wr_full, 0);
        chk("rst_empty",   usr_rd_empty, 1);
        chk("rst_ovf",     usr_ovf, 0);
        chk("rst_wr_data", sd_wr_data, 0);
        chk("rst_rd_data", usr_rd_data, 0);
        usr_rd_en = 1;
        step();
        usr_rd_en = 0;
        chk("pop_empty_data",  usr_rd_data, 0);
        chk("pop_empty_flag",  usr_rd_empty, 1);

        // first write burst
        push_n(8, 1);
        step();
        chk("wb_req", sd_wr_req, 1);
        chk("wb_addr0", sd_wr_addr, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("wb_word", sd_wr_data, i);
            sd_wr_ack = 1;
            step();
        end
        sd_wr_ack = 0;
        chk("wb_req_drop", sd_wr_req, 0);
        chk("wb_addr_next", sd_wr_addr, 8);

        // read burst back
        rd_run = 1;
`ifdef SDRAM_FIFO_RD_PATH_EN
        wait_req(1, 5);
        chk("rb_addr0", sd_rd_addr, 0);
        valids(8, 'hA0);
        chk("rb_req_drop", sd_rd_req, 0);
        chk("rb_addr_next", sd_rd_addr, 8);
        rd_run = 0;
        for (int i = 0; i < 8; i++) begin
            chk("rb_word", usr_rd_data, 'hA0 + i);
            usr_rd_en = 1;
            step();
        end
        usr_rd_en = 0;
        chk("rb_empty_after", usr_rd_empty, 1);
`else
        valids(8, 'hA0);
        chk("norp_rd_req", sd_rd_req, 0);
        chk("norp_empty", usr_rd_empty, 1);
        rd_run = 0;
`endif

        // write and read eligible together: write first, then read
        do_reset();
        rd_run = 1;
        push_n(16, 'h200);
        wait_req(0, 5);
        acks(8);
        step();
        chk("prio_wr_taken", sd_wr_req, 1);
        chk("prio_rd_held", sd_rd_req, 0);
        acks(8);
        step();
        chk("prio_rd_follows", sd_rd_req, RD_EN);
`ifdef SDRAM_FIFO_RD_PATH_EN
        valids(8, 'h300);
        rd_run = 0;
        usr_rd_en = 1;
        repeat (8) step();
        usr_rd_en = 0;
`endif
        rd_run = 0;

        // address wrap across a 3-burst ring
        do_reset();
        push_n(32, 'h400);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) begin
`ifdef SDRAM_FIFO_RD_PATH_EN
                rd_run = 1;
                wait_req(1, 10);
                valids(8, 'h500);
                rd_run = 0;
`else
                repeat (20) step();
                chk("stall_at_cap", sd_wr_req, 0);
                break;
`endif
            end
            wait_req(0, 40);
            chk("wrap_addr", sd_wr_addr, wrap_exp[b]);
            acks(8);
        end

        // overflow with no acks
        do_reset();
        push_n(32, 'h600);
        chk("ovf_full32", usr_wr_full, 1);
        chk("ovf_clear32", usr_ovf, 0);
        push_n(1, 'h6FF);
        chk("ovf_set", usr_ovf, 1);
        chk("ovf_still_full", usr_wr_full, 1);
        repeat (5) step();
        chk("ovf_sticky", usr_ovf, 1);
        do_reset();
        chk("ovf_reset", usr_ovf, 0);

        // reset in the middle of the second burst
        push_n(16, 'h700);
        wait_req(0, 5);
        acks(8);
        wait_req(0, 5);
        chk("mid_addr", sd_wr_addr, 8);
        acks(3);
        rst = 1;
        step();
        chk("mid_req_drop", sd_wr_req, 0);
        chk("mid_full", usr_wr_full, 0);
        chk("mid_wr_data", sd_wr_data, 0);
        rst = 0;
        push_n(8, 'h800);
        wait_req(0, 5);
        chk("mid_restart_addr", sd_wr_addr, BASE);
        chk("mid_restart_word", sd_wr_data, 'h800);
        acks(8);

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 499) == 0);
            usr_wr_en   = ($urandom_range(0, 99) < 40);
            usr_wr_data = DW'($urandom);
            sd_wr_ack   = $urandom_range(0, 1) == 1;
            sd_rd_valid = $urandom_range(0, 1) == 1;
            sd_rd_data  = DW'($urandom);
            rd_run      = ($urandom_range(0, 9) != 0);
            usr_rd_en   = ($urandom_range(0, 99) < 45);
            step();
        end
        clr_in();
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
